// File: rtl/sha1_round_ctrl.sv
// SHA-1 compression sequencer: one round per clock, 16-word rolling schedule, digest add.
// Optional feature macro SHA1_CHAIN_EN: chain=1 at start resumes from the current digest.
module sha1_round_ctrl #(
  parameter int ROUNDS = 80,
  parameter int IDX_W  = 7
) (
  input  logic             wb_clk_i,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             chain,
  input  logic [511:0]     message,
  output logic             busy,
  output logic             done,
  output logic             panic,
  output logic [IDX_W-1:0] round_idx,
  output logic [159:0]     digest
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                 32'h10325476, 32'hC3D2E1F0};

  state_t       state;
  logic [31:0]  w [16];
  logic [31:0]  a, b, c, d, e;
  logic [159:0] h_init, h_sum;
  logic         fin_ph;

  logic [3:0]   slot;
  logic [31:0]  w_mix, w_new, wt, f, k, temp;
  logic [159:0] h_start;

`ifdef SHA1_CHAIN_EN
  assign h_start = chain ? digest : IV;
`else
  logic chain_unused;
  assign chain_unused = chain;
  assign h_start = IV;
`endif

  assign slot = round_idx[3:0];

  // Round datapath: slots t+13, t+8, t+2, t (mod 16) hold W[t-3], W[t-8], W[t-14], W[t-16]
  always_comb begin
    w_mix = w[slot + 4'd13] ^ w[slot + 4'd8] ^ w[slot + 4'd2] ^ w[slot];
    w_new = {w_mix[30:0], w_mix[31]};
    if (round_idx < IDX_W'(16)) begin
      wt = w[slot];
    end else begin
      wt = w_new;
    end
    if (round_idx < IDX_W'(20)) begin
      f = (b & c) | (~b & d);
      k = 32'h5A827999;
    end else if (round_idx < IDX_W'(40)) begin
      f = b ^ c ^ d;
      k = 32'h6ED9EBA1;
    end else if (round_idx < IDX_W'(60)) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8F1BBCDC;
    end else begin
      f = b ^ c ^ d;
      k = 32'hCA62C1D6;
    end
    temp = {a[26:0], a[31:27]} + f + e + k + wt;
  end

  // Sequencer FSM; FINAL takes two cycles so the digest adds are registered before output
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      panic     <= 1'b0;
      round_idx <= '0;
      digest    <= '0;
      h_init    <= '0;
      h_sum     <= '0;
      fin_ph    <= 1'b0;
      {a, b, c, d, e} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      done <= 1'b0;
      if (start && state != IDLE) panic <= 1'b1;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            for (int i = 0; i < 16; i++) w[i] <= message[511 - 32*i -: 32];
            {a, b, c, d, e} <= h_start;
            h_init    <= h_start;
            panic     <= 1'b0;
            round_idx <= '0;
            busy      <= 1'b1;
            state     <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            busy      <= 1'b0;
            round_idx <= '0;
            state     <= IDLE;
          end else begin
            if (round_idx >= IDX_W'(16)) w[slot] <= w_new;
            e <= d;
            d <= c;
            c <= {b[1:0], b[31:2]};
            b <= a;
            a <= temp;
            if (round_idx == IDX_W'(ROUNDS - 1)) begin
              fin_ph <= 1'b0;
              state  <= FINAL;
            end else begin
              round_idx <= round_idx + IDX_W'(1);
            end
          end
        end
        FINAL: begin
          if (abort) begin
            busy      <= 1'b0;
            round_idx <= '0;
            state     <= IDLE;
          end else if (!fin_ph) begin
            h_sum  <= {h_init[159:128] + a, h_init[127:96] + b, h_init[95:64] + c,
                       h_init[63:32] + d, h_init[31:0] + e};
            fin_ph <= 1'b1;
          end else begin
            digest <= h_sum;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          round_idx <= '0;
          state     <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          round_idx <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Scoreboard bench for sha1_round_ctrl using known SHA-1 block digests.
module tb_sha1_round_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, abort, chain;
  logic [511:0] message;
  logic         busy, done, panic;
  logic [6:0]   round_idx;
  logic [159:0] digest;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [159:0] dig;
    int           due;
    bit           ne;
    string        name;
  } exp_t;
  exp_t sb[$];

  localparam logic [159:0] D_ABC   = {32'hA9993E36, 32'h4706816A, 32'hBA3E2571, 32'h7850C26C, 32'h9CD0D89D};
  localparam logic [159:0] D_EMPTY = {32'hDA39A3EE, 32'h5E6B4B0D, 32'h3255BFEF, 32'h95601890, 32'hAFD80709};
  localparam logic [159:0] D_BLK1  = {32'hF4286818, 32'hC37B27AE, 32'h0408F581, 32'h84677148, 32'h4A566572};
  localparam logic [159:0] D_TWO   = {32'h84983E44, 32'h1C3BD26E, 32'hBAAE4A1D, 32'hA1F95129, 32'hE5E54670};

  localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] M_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                                      32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                                      32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M_BLK2  = {448'h0, 32'h00000000, 32'h000001C0};

  sha1_round_ctrl #(.ROUNDS(80), .IDX_W(7)) dut (
    .wb_clk_i (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .chain    (chain),
    .message  (message),
    .busy     (busy),
    .done     (done),
    .panic    (panic),
    .round_idx(round_idx),
    .digest   (digest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation, in value and in cycle
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          x = sb.pop_front();
          if (x.ne) begin
            n_vec++;
            if (digest === x.dig) begin
              n_err++;
              $display("FAIL %s: got %h, expected a value other than %h", x.name, digest, x.dig);
            end
          end else begin
            check(x.name, digest, x.dig);
          end
          check({x.name, "_latency"}, 160'(cyc), 160'(x.due));
        end
      end
    end
  end

  task automatic start_block(input logic [511:0] msg, input logic ch, input bit push,
                             input logic [159:0] exp, input bit ne, input string name);
    exp_t x;
    @(negedge clk);
    message = msg;
    chain   = ch;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      x.dig = exp; x.due = cyc + 82; x.ne = ne; x.name = name;
      sb.push_back(x);
    end
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    if (i == 120) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done in 120 cycles, expected done", name);
    end
  endtask

  task automatic wait_round(input int k);
    int i;
    for (i = 0; i < 120; i++) begin
      @(negedge clk);
      if (round_idx == 7'(k)) break;
    end
    if (i == 120) begin
      n_vec++;
      n_err++;
      $display("FAIL round_timeout: got round_idx %0d, expected %0d", round_idx, k);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_busy"}, 160'(busy), 160'(0));
    check({name, "_done"}, 160'(done), 160'(0));
    check({name, "_panic"}, 160'(panic), 160'(0));
    check({name, "_idx"}, 160'(round_idx), 160'(0));
    check({name, "_digest"}, digest, 160'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; chain = 1'b0; message = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    // "abc" block, busy rises after accepted start
    start_block(M_ABC, 1'b0, 1'b1, D_ABC, 1'b0, "abc");
    check("abc_busy", 160'(busy), 160'(1));
    wait_done("abc");
    check("abc_busy_after", 160'(busy), 160'(0));

    // start while busy sets panic, block completes normally
    start_block(M_ABC, 1'b0, 1'b1, D_ABC, 1'b0, "panic_abc");
    wait_round(10);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("panic_set", 160'(panic), 160'(1));
    check("panic_idx_continues", 160'(round_idx), 160'(11));
    wait_done("panic_abc");

    // empty message; accepted start clears panic
    start_block(M_EMPTY, 1'b0, 1'b1, D_EMPTY, 1'b0, "empty");
    check("panic_cleared", 160'(panic), 160'(0));
    wait_done("empty");

    // abort mid-block: no done, digest kept
    start_block(M_ABC, 1'b0, 1'b0, '0, 1'b0, "aborted");
    wait_round(40);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 160'(busy), 160'(0));
    check("abort_idx", 160'(round_idx), 160'(0));
    repeat (100) @(negedge clk);
    check("abort_digest_kept", digest, D_EMPTY);

    // abort and start together in IDLE: start dropped
    @(negedge clk);
    abort = 1'b1; start = 1'b1; message = M_ABC;
    @(posedge clk);
    #1;
    abort = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_start_busy", 160'(busy), 160'(0));
    check("abort_start_idx", 160'(round_idx), 160'(0));

    // two-block message, second block chained
    start_block(M_BLK1, 1'b0, 1'b1, D_BLK1, 1'b0, "blk1");
    wait_done("blk1");
`ifdef SHA1_CHAIN_EN
    start_block(M_BLK2, 1'b1, 1'b1, D_TWO, 1'b0, "blk2_chain");
`else
    start_block(M_BLK2, 1'b1, 1'b1, D_TWO, 1'b1, "blk2_nochain");
`endif
    wait_done("blk2");

    // asynchronous reset mid-block, then a clean rerun
    start_block(M_ABC, 1'b0, 1'b0, '0, 1'b0, "reset_victim");
    wait_round(20);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("panic_before_reset", 160'(panic), 160'(1));
    wait_round(60);
    #2;
    reset = 1'b1;
    #1;
    check_idle_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset_done", 160'(done), 160'(0));
    start_block(M_ABC, 1'b0, 1'b1, D_ABC, 1'b0, "abc_after_reset");
    wait_done("abc_after_reset");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 160'(sb.size()), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
